// File: rtl/reorder_buffer_pkg.sv
// Shared ROB parameters, tag encoding and instruction-type codes.
// Tags are shared with the register file and reservation stations.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int IDX_W    = 4;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;

  localparam logic [TAG_W-1:0] EMPTY_TAG = 5'b10000;

  typedef enum logic [1:0] {
    TYPE_ALU    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2
  } instr_type_e;

  function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates at tail, captures CDB results,
// retires one entry per cycle from head and flushes on branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              issue_valid,
  input  logic [1:0]        issue_type,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [DATA_W-1:0] issue_pred_pc,
  output logic [TAG_W-1:0]  issue_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [DATA_W-1:0] cdb_real_pc,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              if_commit,
  output logic [REG_W-1:0]  pos_commit,
  output logic [DATA_W-1:0] data_commit,
  output logic [TAG_W-1:0]  tag_commit,
  output logic              store_commit,
  output logic [TAG_W-1:0]  store_tag,
  output logic              clear,
  output logic [DATA_W-1:0] jump_pc
);

  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [1:0]          type_q  [ROB_SIZE];
  logic [REG_W-1:0]    rd_q    [ROB_SIZE];
  logic [DATA_W-1:0]   value_q [ROB_SIZE];
  logic [DATA_W-1:0]   pred_q  [ROB_SIZE];
  logic [DATA_W-1:0]   real_q  [ROB_SIZE];

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              if_commit_q, if_commit_d, store_commit_q, store_commit_d;
  logic              clear_q, clear_d;
  logic [REG_W-1:0]  pos_q, pos_d;
  logic [DATA_W-1:0] data_q, data_d, jump_q, jump_d;
  logic [TAG_W-1:0]  tag_q, tag_d, store_tag_q, store_tag_d;

  logic             full, alloc_go, wb_go, commit_go;
  logic [IDX_W-1:0] cdb_idx;

  assign full    = (count_q == (IDX_W+1)'(ROB_SIZE));
  assign cdb_idx = cdb_tag[IDX_W-1:0];

  // The clear cycle drops all inputs and holds off commit until the flush lands.
  assign alloc_go  = rdy && !clear_q && issue_valid && !full;
  assign wb_go     = rdy && !clear_q && cdb_valid && !cdb_tag[TAG_W-1] && busy_q[cdb_idx];
  assign commit_go = rdy && !clear_q && busy_q[head_q] && ready_q[head_q];

  always_comb begin
    busy_d         = busy_q;
    ready_d        = ready_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    pos_d          = pos_q;
    data_d         = data_q;
    tag_d          = tag_q;
    store_tag_d    = store_tag_q;
    jump_d         = jump_q;
    if_commit_d    = 1'b0;
    store_commit_d = 1'b0;
    clear_d        = 1'b0;
    if (rdy && clear_q) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      if (wb_go) ready_d[cdb_idx] = 1'b1;
      if (alloc_go) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + IDX_W'(1);
      end
      if (commit_go) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + IDX_W'(1);
        if (type_q[head_q] == TYPE_STORE) begin
          store_commit_d = 1'b1;
          store_tag_d    = idx_to_tag(head_q);
        end else begin
          if (rd_q[head_q] != '0) begin
            if_commit_d = 1'b1;
            pos_d       = rd_q[head_q];
            data_d      = value_q[head_q];
            tag_d       = idx_to_tag(head_q);
          end
          if (type_q[head_q] == TYPE_BRANCH && real_q[head_q] != pred_q[head_q]) begin
            clear_d = 1'b1;
            jump_d  = real_q[head_q];
          end
        end
      end
      count_d = count_q + (IDX_W+1)'(alloc_go) - (IDX_W+1)'(commit_go);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      if_commit_q    <= 1'b0;
      store_commit_q <= 1'b0;
      clear_q        <= 1'b0;
      pos_q          <= '0;
      data_q         <= '0;
      tag_q          <= '0;
      store_tag_q    <= '0;
      jump_q         <= '0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      if_commit_q    <= if_commit_d;
      store_commit_q <= store_commit_d;
      clear_q        <= clear_d;
      pos_q          <= pos_d;
      data_q         <= data_d;
      tag_q          <= tag_d;
      store_tag_q    <= store_tag_d;
      jump_q         <= jump_d;
    end
  end

  // Payload storage needs no reset: busy/ready gate every read.
  always_ff @(posedge clk) begin
    if (alloc_go) begin
      type_q[tail_q] <= issue_type;
      rd_q[tail_q]   <= issue_rd;
      pred_q[tail_q] <= issue_pred_pc;
    end
    if (wb_go) begin
      value_q[cdb_idx] <= cdb_data;
      real_q[cdb_idx]  <= cdb_real_pc;
    end
  end

  always_comb begin
    q1_ready = 1'b0;
    q1_data  = '0;
    if (q1_tag[TAG_W-1]) begin
      q1_ready = 1'b1;
    end else if (cdb_valid && cdb_tag == q1_tag) begin
      q1_ready = 1'b1;
      q1_data  = cdb_data;
    end else if (ready_q[q1_tag[IDX_W-1:0]]) begin
      q1_ready = 1'b1;
      q1_data  = value_q[q1_tag[IDX_W-1:0]];
    end
  end

  always_comb begin
    q2_ready = 1'b0;
    q2_data  = '0;
    if (q2_tag[TAG_W-1]) begin
      q2_ready = 1'b1;
    end else if (cdb_valid && cdb_tag == q2_tag) begin
      q2_ready = 1'b1;
      q2_data  = cdb_data;
    end else if (ready_q[q2_tag[IDX_W-1:0]]) begin
      q2_ready = 1'b1;
      q2_data  = value_q[q2_tag[IDX_W-1:0]];
    end
  end

  assign issue_tag    = idx_to_tag(tail_q);
  assign rob_full     = full;
  assign if_commit    = if_commit_q;
  assign pos_commit   = pos_q;
  assign data_commit  = data_q;
  assign tag_commit   = tag_q;
  assign store_commit = store_commit_q;
  assign store_tag    = store_tag_q;
  assign clear        = clear_q;
  assign jump_pc      = jump_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retire events,
// a negedge monitor pops and compares them whenever a commit pulse appears.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pred_pc;
  logic [4:0]  issue_tag;
  logic        rob_full;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data, cdb_real_pc;
  logic [4:0]  q1_tag, q2_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        if_commit;
  logic [4:0]  pos_commit;
  logic [31:0] data_commit;
  logic [4:0]  tag_commit;
  logic        store_commit;
  logic [4:0]  store_tag;
  logic        clear;
  logic [31:0] jump_pc;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_pc(issue_pred_pc), .issue_tag(issue_tag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_real_pc(cdb_real_pc),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .if_commit(if_commit), .pos_commit(pos_commit), .data_commit(data_commit),
    .tag_commit(tag_commit), .store_commit(store_commit), .store_tag(store_tag),
    .clear(clear), .jump_pc(jump_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e_if, e_st, e_clr;
    logic [4:0]  pos;
    logic [31:0] data;
    logic [4:0]  tag;
    logic [4:0]  st_tag;
    logic [31:0] jump;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic e_if, input logic e_st, input logic e_clr, input logic [4:0] pos,
                      input logic [31:0] data, input logic [4:0] tag, input logic [4:0] st_tag,
                      input logic [31:0] jump);
    exp_t e;
    e.e_if = e_if; e.e_st = e_st; e.e_clr = e_clr;
    e.pos = pos; e.data = data; e.tag = tag; e.st_tag = st_tag; e.jump = jump;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pred_pc = pc;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] tag, input logic [31:0] d, input logic [31:0] rpc);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = d; cdb_real_pc = rpc;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    repeat (3) tick();
  endtask

  // Monitor: every commit pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && (if_commit === 1'b1 || store_commit === 1'b1 || clear === 1'b1)) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_retire: if=%0b st=%0b clr=%0b expected no pulse at %0t",
                   if_commit, store_commit, clear, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("mon_if_commit", 32'(if_commit), 32'(mon_e.e_if));
          chk("mon_store_commit", 32'(store_commit), 32'(mon_e.e_st));
          chk("mon_clear", 32'(clear), 32'(mon_e.e_clr));
          if (mon_e.e_if) begin
            chk("mon_pos", 32'(pos_commit), 32'(mon_e.pos));
            chk("mon_data", data_commit, mon_e.data);
            chk("mon_tag", 32'(tag_commit), 32'(mon_e.tag));
          end
          if (mon_e.e_st) chk("mon_store_tag", 32'(store_tag), 32'(mon_e.st_tag));
          if (mon_e.e_clr) chk("mon_jump_pc", jump_pc, mon_e.jump);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pred_pc = 32'd0;
    cdb_valid = 1'b0; cdb_tag = 5'h10; cdb_data = 32'd0; cdb_real_pc = 32'd0;
    q1_tag = 5'h10; q2_tag = 5'h10;
    do_reset();

    chk("rst_if_commit", 32'(if_commit), 0);
    chk("rst_store_commit", 32'(store_commit), 0);
    chk("rst_clear", 32'(clear), 0);
    chk("rst_pos", 32'(pos_commit), 0);
    chk("rst_data", data_commit, 0);
    chk("rst_tag", 32'(tag_commit), 0);
    chk("rst_jump", jump_pc, 0);
    chk("rst_issue_tag", 32'(issue_tag), 0);
    chk("rst_full", 32'(rob_full), 0);

    // Basic ALU retire, checking the exact latency.
    push(1, 0, 0, 5'd5, 32'h1234, 5'd0, 5'd0, 32'd0);
    issue(2'd0, 5'd5, 32'd0);
    wb(5'd0, 32'h1234, 32'd0);
    chk("alu_not_yet", 32'(if_commit), 0);
    tick();
    chk("alu_if_commit", 32'(if_commit), 1);
    chk("alu_pos", 32'(pos_commit), 5);
    chk("alu_data", data_commit, 32'h1234);
    chk("alu_tag", 32'(tag_commit), 0);
    drain();

    // Fill to capacity, ignored 17th issue, then wrap.
    do_reset();
    for (int i = 0; i < 16; i++) issue(2'd0, 5'(i + 1), 32'd0);
    chk("full_set", 32'(rob_full), 1);
    chk("full_tag", 32'(issue_tag), 0);
    issue(2'd0, 5'd31, 32'd0);
    chk("full_ignore_tag", 32'(issue_tag), 0);
    chk("full_ignore_full", 32'(rob_full), 1);
    push(1, 0, 0, 5'd1, 32'h1000, 5'd0, 5'd0, 32'd0);
    wb(5'd0, 32'h1000, 32'd0);
    chk("full_before_commit", 32'(rob_full), 1);
    tick();
    chk("full_dropped", 32'(rob_full), 0);
    chk("wrap_tag", 32'(issue_tag), 0);
    issue(2'd0, 5'd20, 32'd0);
    chk("wrap_next_tag", 32'(issue_tag), 1);
    chk("wrap_full_again", 32'(rob_full), 1);
    for (int i = 1; i < 16; i++) begin
      push(1, 0, 0, 5'(i + 1), 32'h1000 + 32'(i), 5'(i), 5'd0, 32'd0);
      wb(5'(i), 32'h1000 + 32'(i), 32'd0);
    end
    push(1, 0, 0, 5'd20, 32'h2000, 5'd0, 5'd0, 32'd0);
    wb(5'd0, 32'h2000, 32'd0);
    drain();
    chk("drained_not_full", 32'(rob_full), 0);

    // Mispredicted branch flushes a younger entry.
    do_reset();
    issue(2'd2, 5'd0, 32'h100);
    issue(2'd0, 5'd7, 32'd0);
    push(0, 0, 1, 5'd0, 32'd0, 5'd0, 5'd0, 32'h200);
    wb(5'd0, 32'd0, 32'h200);
    tick();
    chk("br_clear", 32'(clear), 1);
    chk("br_jump", jump_pc, 32'h200);
    cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_data = 32'h55; cdb_real_pc = 32'd0;
    tick();
    cdb_valid = 1'b0;
    q1_tag = 5'd1;
    #1;
    chk("br_clear_pulse", 32'(clear), 0);
    chk("br_flush_tag", 32'(issue_tag), 0);
    chk("br_flush_full", 32'(rob_full), 0);
    chk("br_young_ignored", 32'(q1_ready), 0);
    q1_tag = 5'h10;
    drain();

    // CDB bypass on lookup; rd=0 ALU entries retire silently.
    for (int i = 0; i < 4; i++) issue(2'd0, 5'd0, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'hABCD; cdb_real_pc = 32'd0;
    q1_tag = 5'd3; q2_tag = 5'd2;
    #1;
    chk("byp_q1_ready", 32'(q1_ready), 1);
    chk("byp_q1_data", q1_data, 32'hABCD);
    chk("byp_q2_not_ready", 32'(q2_ready), 0);
    q2_tag = 5'h10;
    #1;
    chk("empty_q2_ready", 32'(q2_ready), 1);
    chk("empty_q2_data", q2_data, 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("stored_q1_ready", 32'(q1_ready), 1);
    chk("stored_q1_data", q1_data, 32'hABCD);
    q1_tag = 5'h10;
    wb(5'd0, 32'h11, 32'd0);
    wb(5'd1, 32'h22, 32'd0);
    wb(5'd2, 32'h33, 32'd0);
    repeat (5) tick();
    chk("silent_tag", 32'(issue_tag), 4);

    // Store retire pulse.
    push(0, 1, 0, 5'd0, 32'd0, 5'd0, 5'd4, 32'd0);
    issue(2'd1, 5'd0, 32'd0);
    wb(5'd4, 32'd0, 32'd0);
    chk("st_not_yet", 32'(store_commit), 0);
    tick();
    chk("st_pulse", 32'(store_commit), 1);
    chk("st_tag", 32'(store_tag), 4);
    chk("st_no_regwrite", 32'(if_commit), 0);
    tick();
    chk("st_pulse_end", 32'(store_commit), 0);
    drain();

    // rdy=0 freezes a ready head and blocks issue.
    push(1, 0, 0, 5'd9, 32'h9999, 5'd5, 5'd0, 32'd0);
    issue(2'd0, 5'd9, 32'd0);
    wb(5'd5, 32'h9999, 32'd0);
    rdy = 1'b0;
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_no_commit", 32'(if_commit), 0);
      chk("hold_tag", 32'(issue_tag), 6);
    end
    issue_valid = 1'b0;
    rdy = 1'b1;
    tick();
    chk("resume_commit", 32'(if_commit), 1);
    chk("resume_pos", 32'(pos_commit), 9);
    chk("resume_data", data_commit, 32'h9999);
    drain();

    // Correctly predicted branch with a link register.
    push(1, 0, 0, 5'd1, 32'h44, 5'd6, 5'd0, 32'd0);
    issue(2'd2, 5'd1, 32'h300);
    wb(5'd6, 32'h44, 32'h300);
    tick();
    chk("brok_commit", 32'(if_commit), 1);
    chk("brok_no_clear", 32'(clear), 0);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
